// File: rtl/param_updown_counter_if.sv
// Control and status bundle for param_updown_counter; master drives the
// controls, slave (the counter) drives the registered and decoded status.
interface param_updown_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             dir;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] modulus;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             ovf;
  logic             at_max;
  logic             at_zero;

  modport master (
    output en, dir, clr, load, load_val, modulus,
    input  cnt, tc, ovf, at_max, at_zero
  );

  modport slave (
    input  en, dir, clr, load, load_val, modulus,
    output cnt, tc, ovf, at_max, at_zero
  );
endinterface

// File: rtl/param_updown_counter.sv
// Up/down modulo counter with clear, clamped load, terminal-count pulse and
// sticky overflow; SAT_MODE selects wrap (0) or saturate (1) at the bounds.
module param_updown_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter bit          SAT_MODE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  param_updown_counter_if.slave bus
);

  logic [WIDTH-1:0] cnt_q;
  logic             tc_q;
  logic             ovf_q;
  logic [WIDTH-1:0] step_next;
  logic             step_event;
  logic [WIDTH-1:0] load_next;

  // A count above a freshly lowered modulus is still treated as "at or past
  // the top", so the next up step is a boundary event rather than cnt+1.
  always_comb begin
    step_next  = cnt_q;
    step_event = 1'b0;
    if (bus.dir) begin
      if (cnt_q >= bus.modulus) begin
        step_event = 1'b1;
        step_next  = SAT_MODE ? bus.modulus : '0;
      end else begin
        step_next = cnt_q + WIDTH'(1);
      end
    end else begin
      if (cnt_q == '0) begin
        step_event = 1'b1;
        step_next  = SAT_MODE ? '0 : bus.modulus;
      end else begin
        step_next = cnt_q - WIDTH'(1);
      end
    end
  end

  always_comb begin
    load_next = (bus.load_val > bus.modulus) ? bus.modulus : bus.load_val;
  end

  always_ff @(posedge clk) begin
    if (reset || bus.clr) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (bus.load) begin
      cnt_q <= load_next;
      tc_q  <= 1'b0;
    end else if (bus.en) begin
      cnt_q <= step_next;
      tc_q  <= step_event;
      if (step_event) begin
        ovf_q <= 1'b1;
      end
    end else begin
      tc_q <= 1'b0;
    end
  end

  assign bus.cnt     = cnt_q;
  assign bus.tc      = tc_q;
  assign bus.ovf     = ovf_q;
  assign bus.at_max  = (cnt_q >= bus.modulus);
  assign bus.at_zero = (cnt_q == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: one wrapping and one saturating
// instance, each checked against hand-computed expected values.
module tb_param_updown_counter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  param_updown_counter_if #(.WIDTH(4)) w_bus ();
  param_updown_counter_if #(.WIDTH(4)) s_bus ();

  param_updown_counter #(.WIDTH(4), .SAT_MODE(1'b0)) u_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (w_bus)
  );

  param_updown_counter #(.WIDTH(4), .SAT_MODE(1'b1)) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (s_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_w(input string tag, input int c, input int t, input int o);
    check({tag, ".cnt"}, 32'(w_bus.cnt), 32'(c));
    check({tag, ".tc"},  32'(w_bus.tc),  32'(t));
    check({tag, ".ovf"}, 32'(w_bus.ovf), 32'(o));
  endtask

  task automatic chk_s(input string tag, input int c, input int t, input int o);
    check({tag, ".cnt"}, 32'(s_bus.cnt), 32'(c));
    check({tag, ".tc"},  32'(s_bus.tc),  32'(t));
    check({tag, ".ovf"}, 32'(s_bus.ovf), 32'(o));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    w_bus.en = 1'b1; w_bus.dir = 1'b1; w_bus.clr = 1'b0; w_bus.load = 1'b1;
    w_bus.load_val = 4'd7; w_bus.modulus = 4'd9;
    s_bus.en = 1'b1; s_bus.dir = 1'b1; s_bus.clr = 1'b0; s_bus.load = 1'b0;
    s_bus.load_val = 4'd0; s_bus.modulus = 4'd12;
    #1;
    tick();
    chk_w("reset_w", 0, 0, 0);
    chk_s("reset_s", 0, 0, 0);
    check("reset_at_zero", 32'(w_bus.at_zero), 32'd1);

    // Wrap count-up through modulus 9
    w_bus.load = 1'b0;
    reset = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk_w($sformatf("up9_%0d", i), i, 0, 0);
    end
    check("up9_at_max", 32'(w_bus.at_max), 32'd1);
    check("up9_at_zero", 32'(w_bus.at_zero), 32'd0);
    tick();
    chk_w("up9_wrap", 0, 1, 1);
    tick();
    chk_w("up9_after", 1, 0, 1);

    // Clear, then down count from 0 with modulus 15
    w_bus.clr = 1'b1;
    tick();
    chk_w("clr", 0, 0, 0);
    w_bus.clr = 1'b0; w_bus.modulus = 4'd15; w_bus.dir = 1'b0;
    tick();
    chk_w("dn15_wrap", 15, 1, 1);
    tick();
    chk_w("dn15_14", 14, 0, 1);
    tick();
    chk_w("dn15_13", 13, 0, 1);

    // Load keeps ovf; then clr+load+en together
    w_bus.en = 1'b0; w_bus.load = 1'b1; w_bus.load_val = 4'd7;
    tick();
    chk_w("load7", 7, 0, 1);
    w_bus.clr = 1'b1; w_bus.load_val = 4'd5; w_bus.en = 1'b1;
    tick();
    chk_w("clr_prio", 0, 0, 0);
    w_bus.clr = 1'b0;

    // Load clamps to modulus
    w_bus.en = 1'b0; w_bus.modulus = 4'd9; w_bus.load_val = 4'd12;
    tick();
    chk_w("load_clamp", 9, 0, 0);

    // Reset mid-count, then resume
    w_bus.modulus = 4'd15; w_bus.load_val = 4'd5;
    tick();
    w_bus.load = 1'b0; w_bus.en = 1'b1; w_bus.dir = 1'b1;
    tick();
    chk_w("pre_reset", 6, 0, 0);
    reset = 1'b1;
    tick();
    chk_w("mid_reset", 0, 0, 0);
    reset = 1'b0;
    tick();
    chk_w("resume", 1, 0, 0);

    // Hold with en low
    w_bus.en = 1'b0;
    tick();
    tick();
    chk_w("hold", 1, 0, 0);

    // Lowering modulus below cnt holds cnt until next step
    w_bus.load = 1'b1; w_bus.load_val = 4'd10;
    tick();
    w_bus.load = 1'b0; w_bus.modulus = 4'd3;
    tick();
    chk_w("mod_low_hold", 10, 0, 0);
    check("mod_low_at_max", 32'(w_bus.at_max), 32'd1);
    w_bus.en = 1'b1;
    tick();
    chk_w("mod_low_step", 0, 1, 1);

    // modulus 0: every step is a boundary event
    w_bus.modulus = 4'd0;
    tick();
    chk_w("mod0_up", 0, 1, 1);
    w_bus.dir = 1'b0;
    tick();
    chk_w("mod0_dn", 0, 1, 1);

    // Direction changes take effect immediately
    w_bus.en = 1'b0; w_bus.modulus = 4'd15; w_bus.load = 1'b1; w_bus.load_val = 4'd4;
    tick();
    w_bus.load = 1'b0; w_bus.en = 1'b1; w_bus.dir = 1'b1;
    tick();
    chk_w("dir_up", 5, 0, 1);
    w_bus.dir = 1'b0;
    tick();
    chk_w("dir_dn", 4, 0, 1);
    w_bus.dir = 1'b1;
    tick();
    chk_w("dir_up2", 5, 0, 1);
    w_bus.en = 1'b0;

    // Saturating instance: clamped load then repeated up steps at the top
    s_bus.en = 1'b0; s_bus.load = 1'b1; s_bus.load_val = 4'd14;
    tick();
    chk_s("sat_load", 12, 0, 0);
    s_bus.load = 1'b0; s_bus.en = 1'b1; s_bus.dir = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_s($sformatf("sat_top_%0d", i), 12, 1, 1);
    end
    s_bus.dir = 1'b0;
    tick();
    chk_s("sat_dn", 11, 0, 1);
    s_bus.en = 1'b0; s_bus.load = 1'b1; s_bus.load_val = 4'd0;
    tick();
    s_bus.load = 1'b0; s_bus.en = 1'b1;
    tick();
    chk_s("sat_bot_1", 0, 1, 1);
    tick();
    chk_s("sat_bot_2", 0, 1, 1);
    s_bus.en = 1'b0;
    tick();
    chk_s("sat_idle", 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter, load and modulus width in bits; legal range 2..32.
REQ-002 Parameter SAT_MODE, default 0: boundary behaviour; 0 wraps, 1 saturates.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 en  input  1  count enable; one step per clk while high.
REQ-006 dir  input  1  step direction; 1 counts up, 0 counts down.
REQ-007 clr  input  1  synchronous clear of cnt and ovf.
REQ-008 load  input  1  synchronous load of load_val into cnt.
REQ-009 load_val  input  WIDTH  value loaded when load is high.
REQ-010 modulus  input  WIDTH  terminal count; cnt range is 0..modulus inclusive.
REQ-011 cnt  output  WIDTH  registered count value.
REQ-012 tc  output  1  registered one-cycle pulse marking a boundary event.
REQ-013 ovf  output  1  registered sticky flag; set by any boundary event.
REQ-014 at_max  output  1  combinational; high when cnt >= modulus.
REQ-015 at_zero  output  1  combinational; high when cnt == 0.

Function
REQ-016 Per-edge priority SHALL be: reset > clr > load > en; only the highest active operation takes effect.
REQ-017 clr SHALL set cnt=0, ovf=0, tc=0 on the next edge, regardless of load and en.
REQ-018 load SHALL set cnt=min(load_val, modulus) on the next edge, set tc=0, and leave ovf unchanged.
REQ-019 With en=0 and no higher-priority operation, cnt and ovf SHALL hold and tc SHALL be 0.
REQ-020 Up step, cnt < modulus: cnt SHALL become cnt+1; no boundary event.
REQ-021 Up step, cnt >= modulus, is a boundary event: cnt SHALL become 0 if SAT_MODE=0, and modulus if SAT_MODE=1.
REQ-022 Down step, cnt > 0: cnt SHALL become cnt-1; no boundary event.
REQ-023 Down step, cnt == 0, is a boundary event: cnt SHALL become modulus if SAT_MODE=0, and remain 0 if SAT_MODE=1.
REQ-024 On a boundary event, tc SHALL be 1 in the same cycle the new cnt is visible (one edge after the enabling edge), and ovf SHALL be set.
REQ-025 tc SHALL be 0 in every cycle not immediately following a boundary event; back-to-back events SHALL hold tc high on consecutive cycles.
REQ-026 In saturate mode, each enabled step while held at the boundary SHALL count as a boundary event.
REQ-027 modulus SHALL be sampled every cycle; lowering modulus below cnt SHALL NOT change cnt until the next step, load or clr.
REQ-028 modulus == 0: cnt SHALL stay 0, and every enabled step SHALL be a boundary event.
REQ-029 Changing dir between cycles SHALL take effect on the next enabled step, with no extra latency or lost step.
REQ-030 All arithmetic SHALL be WIDTH bits, with no carry out beyond the behaviour defined above.

Reset
REQ-031 With reset high at a clk edge: cnt=0, tc=0, ovf=0 after that edge, overriding every other input.
REQ-032 reset asserted mid-count SHALL take effect at the next edge only; there SHALL be no asynchronous effect between edges.
REQ-033 The first operation after reset deasserts SHALL be evaluated at the first edge where reset is sampled low.

Verification (WIDTH=4)
REQ-034 SAT_MODE=0, modulus=9, dir=1, en=1 from reset: cnt 0..9 then 0; tc=1 only in the cycle cnt shows 0 after 9; ovf=1 from then on.
REQ-035 SAT_MODE=0, modulus=15, dir=0, en=1 from cnt=0: cnt goes to 15 with tc=1, then 14, 13; ovf=1.
REQ-036 SAT_MODE=1, modulus=12, load=1 with load_val=14: cnt=12; then 3 up-steps: cnt stays 12, tc=1 on 3 consecutive cycles.
REQ-037 clr, load (load_val=5) and en all high in one cycle with cnt=7, ovf=1: next cycle cnt=0, ovf=0, tc=0.
REQ-038 reset asserted for one edge at cnt=6, en=1: next cycle cnt=0, tc=0, ovf=0; counting resumes at 1 on the following edge.
REQ-039 modulus changed from 15 to 3 with cnt=10, dir=1: cnt holds at 10 until the next step, then goes to 0 (SAT_MODE=0) with tc=1.
